// File: rtl/ct_stream_sequencer.sv
// ct_stream_sequencer: buffers one weight vector and four subject vectors,
// then on start pulses the CT column clear, streams one beat per entry,
// waits out the column latency and flags when the column results are final.
module ct_stream_sequencer #(
  parameter int DEPTH = 4,
  parameter int DRAIN = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [2:0]    wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_err,
  input  logic          start,
  output logic          busy,
  output logic          ct_clear,
  output logic [7:0]    weight_out,
  output logic [7:0]    subject_out_1,
  output logic [7:0]    subject_out_2,
  output logic [7:0]    subject_out_3,
  output logic [7:0]    subject_out_4,
  output logic          result_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [7:0]  LAST_K     = 8'(DEPTH - 1);
  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN - 1);
  localparam logic [AW:0] ADDR_LIM   = (AW + 1)'(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  // Row 0 holds the weight vector, rows 1..4 the subject lanes.
  logic [7:0]    buf_q [0:4][0:DEPTH-1];
  logic [7:0]    weight_q;
  logic [7:0]    subj_q [0:3];
  logic          ct_clear_q;
  logic          busy_q;
  logic          result_valid_q;
  logic          wr_err_q;
  logic          wr_accept;
  logic          stream_d;
  logic [AW-1:0] rd_idx;

  // Writes only land while idle and addressed inside the buffers.
  assign wr_accept = wr_en && (state_q == S_IDLE) && (wr_sel <= 3'd4) &&
                     ({1'b0, wr_addr} < ADDR_LIM);

  // Next-state and step counter; start outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        state_d = S_STREAM;
        cnt_d   = 8'd0;
      end
      S_STREAM: begin
        if (cnt_q == LAST_K) begin
          cnt_d   = 8'd0;
          state_d = (DRAIN == 0) ? S_DONE : S_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state, so they line up with it.
  assign stream_d = (state_d == S_STREAM);
  assign rd_idx   = cnt_d[AW-1:0];

  // State and step counter registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Vector buffers; cleared only by reset, otherwise persist across runs.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int r = 0; r < 5; r++) begin
        for (int e = 0; e < DEPTH; e++) begin
          buf_q[r][e] <= 8'd0;
        end
      end
    end else if (wr_accept) begin
      buf_q[wr_sel][wr_addr] <= wr_data;
    end
  end

  // Control outputs and the write-reject pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      ct_clear_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      wr_err_q       <= 1'b0;
      weight_q       <= 8'd0;
    end else begin
      ct_clear_q     <= (state_d == S_CLR);
      busy_q         <= (state_d != S_IDLE);
      result_valid_q <= (state_d == S_DONE);
      wr_err_q       <= wr_en && !wr_accept;
      weight_q       <= stream_d ? buf_q[0][rd_idx] : 8'd0;
    end
  end

  // One output register per subject lane; zero outside STREAM.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (clear) begin
          subj_q[gi] <= 8'd0;
        end else begin
          subj_q[gi] <= stream_d ? buf_q[gi+1][rd_idx] : 8'd0;
        end
      end
    end
  endgenerate

  assign wr_err        = wr_err_q;
  assign busy          = busy_q;
  assign ct_clear      = ct_clear_q;
  assign result_valid  = result_valid_q;
  assign weight_out    = weight_q;
  assign subject_out_1 = subj_q[0];
  assign subject_out_2 = subj_q[1];
  assign subject_out_3 = subj_q[2];
  assign subject_out_4 = subj_q[3];

endmodule

// File: tb/tb_ct_stream_sequencer.sv
// tb_ct_stream_sequencer: directed and random stimulus against a run-position
// reference model; a monitor compares every output cycle and checks the dot
// products an attached CT column would see at each result_valid.
module tb_ct_stream_sequencer;

  localparam int DEPTH = 4;
  localparam int DRAIN = 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int TOTAL = DEPTH + DRAIN + 2;

  logic          clk = 1'b0;
  logic          clear, wr_en, start;
  logic [2:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_err, busy, ct_clear, result_valid;
  logic [7:0]    weight_out, subject_out_1, subject_out_2, subject_out_3, subject_out_4;

  always #5 clk = ~clk;

  ct_stream_sequencer #(.DEPTH(DEPTH), .DRAIN(DRAIN)) dut (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .start(start), .busy(busy),
    .ct_clear(ct_clear), .weight_out(weight_out),
    .subject_out_1(subject_out_1), .subject_out_2(subject_out_2),
    .subject_out_3(subject_out_3), .subject_out_4(subject_out_4),
    .result_valid(result_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rv_seen  = 0;
  int rv_exp   = 0;

  logic [43:0] exp_q[$];
  logic [31:0] dot_q[$];

  // Reference model: buffer contents and position within the current run
  // (-1 = idle, 0 = clear cycle, 1..DEPTH = stream beats, TOTAL-1 = done).
  logic [7:0] mem [0:4][0:DEPTH-1];
  int         pos = -1;
  logic [7:0] tbl [0:4][0:DEPTH-1];

  task automatic step(input logic c, input logic we, input logic [2:0] sel,
                      input logic [AW-1:0] a, input logic [7:0] d, input logic st);
    logic        err;
    logic [43:0] e;
    logic [7:0]  bw, b1, b2, b3, b4;
    logic [31:0] dots;
    int          acc;
    @(negedge clk);
    clear = c; wr_en = we; wr_sel = sel; wr_addr = a; wr_data = d; start = st;
    err = 1'b0;
    if (c) begin
      for (int r = 0; r < 5; r++)
        for (int k = 0; k < DEPTH; k++) mem[r][k] = 8'd0;
      pos = -1;
      dot_q.delete();
    end else begin
      if (we) begin
        if (pos < 0 && sel <= 3'd4 && int'(a) < DEPTH) mem[sel][a] = d;
        else err = 1'b1;
      end
      if (pos < 0) begin
        if (st) begin
          pos = 0;
          for (int j = 1; j <= 4; j++) begin
            acc = 0;
            for (int k = 0; k < DEPTH; k++) acc += int'(mem[0][k]) * int'(mem[j][k]);
            dots[(j-1)*8 +: 8] = acc[7:0];
          end
          dot_q.push_back(dots);
        end
      end else if (pos == TOTAL - 1) begin
        pos = -1;
      end else begin
        pos++;
      end
    end
    {bw, b1, b2, b3, b4} = '0;
    if (pos >= 1 && pos <= DEPTH) begin
      bw = mem[0][pos-1]; b1 = mem[1][pos-1]; b2 = mem[2][pos-1];
      b3 = mem[3][pos-1]; b4 = mem[4][pos-1];
    end
    e = {(pos >= 0), (pos == 0), (pos == TOTAL - 1), err, bw, b1, b2, b3, b4};
    if (pos == TOTAL - 1) rv_exp++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b0);
  endtask

  task automatic load_tbl();
    for (int l = 0; l < 5; l++)
      for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 3'(l), AW'(k), tbl[l][k], 1'b0);
  endtask

  // Monitor: per-cycle output compare plus an 8-bit wrapping column model.
  initial begin : monitor
    logic [43:0] e, a;
    logic [7:0]  acc [0:3];
    logic [7:0]  subj [0:3];
    logic [31:0] dots;
    for (int j = 0; j < 4; j++) acc[j] = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      a = {busy, ct_clear, result_valid, wr_err, weight_out,
           subject_out_1, subject_out_2, subject_out_3, subject_out_4};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t actual=%h required=%h (busy,clr,rv,err,w,s1..s4)",
                   $time, a, e);
        end
      end
      subj[0] = subject_out_1; subj[1] = subject_out_2;
      subj[2] = subject_out_3; subj[3] = subject_out_4;
      if (ct_clear) begin
        for (int j = 0; j < 4; j++) acc[j] = 8'd0;
      end else if (busy) begin
        for (int j = 0; j < 4; j++) acc[j] = acc[j] + weight_out * subj[j];
      end
      if (result_valid) begin
        rv_seen++;
        n_checks++;
        if (dot_q.size() == 0) begin
          n_fail++;
          $display("FAIL calc_out t=%0t actual=result_valid required=no result pending", $time);
        end else begin
          dots = dot_q.pop_front();
          if ({acc[0], acc[1], acc[2], acc[3]} !== {dots[7:0], dots[15:8], dots[23:16], dots[31:24]}) begin
            n_fail++;
            $display("FAIL calc_out t=%0t actual=%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d",
                     $time, acc[0], acc[1], acc[2], acc[3],
                     dots[7:0], dots[15:8], dots[23:16], dots[31:24]);
          end else begin
            $display("run done t=%0t calc_out=%0d,%0d,%0d,%0d", $time,
                     acc[0], acc[1], acc[2], acc[3]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    clear = 1'b1; wr_en = 1'b0; wr_sel = 3'd0; wr_addr = '0; wr_data = 8'd0; start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tbl[0][k] = 8'(k + 1);
      tbl[1][k] = 8'd1;
      tbl[2][k] = (k == 0) ? 8'd2 : 8'd0;
      tbl[3][k] = (k == DEPTH - 1) ? 8'd5 : 8'd0;
      tbl[4][k] = 8'd4;
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, '0, 8'd0, 1'b0);
    idle(2);

    // Basic run with the reference vectors.
    load_tbl();
    step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(8);

    // Writes during STREAM and with illegal selects are rejected.
    step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(1);
    step(1'b0, 1'b1, 3'd0, AW'(1), 8'hAA, 1'b0);
    step(1'b0, 1'b1, 3'd2, AW'(2), 8'h55, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 3'd6, AW'(0), 8'h77, 1'b0);
    step(1'b0, 1'b1, 3'd7, AW'(3), 8'h66, 1'b0);
    step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(8);

    // start re-asserted in cycles 2 and 5 is ignored.
    step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(4);

    // clear in cycle 3 aborts; the next run streams zeros.
    step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(3);
    step(1'b1, 1'b0, 3'd0, '0, 8'd0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(8);

    // Back-to-back runs with start held high.
    load_tbl();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 3'd0, '0, 8'd0, 1'b1);
    idle(8);

    // Same-cycle write of W[0]=9 with start.
    step(1'b0, 1'b1, 3'd0, AW'(0), 8'd9, 1'b1);
    idle(8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
           3'($urandom_range(0, 7)), AW'($urandom_range(0, (1 << AW) - 1)),
           8'($urandom), ($urandom_range(0, 5) == 0));
    end
    idle(10);

    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    n_checks++;
    if (rv_seen != rv_exp) begin
      n_fail++;
      $display("FAIL rv_count actual=%0d required=%0d", rv_seen, rv_exp);
    end
    n_checks++;
    if (dot_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending actual=%0d results,%0d cycles required=0,0",
               dot_q.size(), exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
